qspi_read_sequencer: RTL and testbench

//  Sequences multi-byte flash reads onto the single-byte qspi_controller. Accepts one block request
//  (start address, byte count, bus mode) and issues consecutive one-byte read transactions.

---
 rtl/qspi_read_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_read_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_read_sequencer.sv
// Splits a block flash read into single-byte qspi_controller transactions, tracking
// die changes, downstream FIFO back-pressure and a per-byte completion timeout.
module qspi_read_sequencer #(
    parameter int unsigned DIE_BIT     = 25,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             system_clk,
    input  logic             system_reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [1:0]       req_mode,
    input  logic             abort,
    input  logic             fifo_afull,
    input  logic             qspi_ready,
    input  logic             qspi_write_req,
    input  logic             qspi_read_done,
    output logic             qspi_read_flag,
    output logic [31:0]      qspi_read_addr,
    output logic [1:0]       qspi_mode,
    output logic             qspi_switch_die,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [LEN_W-1:0] bytes_rcvd
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         fin_code;
    logic [LEN_W-1:0]   rem_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               abort_pend_q;
    logic               cur_die_q;
    logic               die_known_q;

    logic               abort_any;
    logic               accept;
    logic               rem_last;
    logic               tmo_hit;

    logic               ready_d;
    logic               busy_d;
    logic               done_d;
    logic [1:0]         status_d;
    logic               flag_d;
    logic               switch_d;

    assign abort_any = abort || abort_pend_q;
    assign accept    = (state_q == S_IDLE) && req_valid && req_ready;
    assign rem_last  = (rem_q == LEN_W'(1));
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fin_code is the status reported when entering DONE
    always_comb begin
        state_d  = state_q;
        fin_code = ST_OK;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_mode == MODE_ILLEGAL) begin
                        state_d  = S_DONE;
                        fin_code = ST_ILLEGAL;
                    end else if (req_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (abort_any) begin
                    state_d  = S_DONE;
                    fin_code = ST_ABORTED;
                end else if (qspi_ready && !fifo_afull) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (qspi_read_done) begin
                    if (rem_last) begin
                        state_d = S_DONE;
                    end else if (abort_any) begin
                        state_d  = S_DONE;
                        fin_code = ST_ABORTED;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    fin_code = ST_TIMEOUT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop aligned with its state
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        status_d = done_d ? fin_code : ST_OK;
        flag_d   = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE);
        switch_d = 1'b0;
        if (state_d == S_ISSUE) begin
            switch_d = !die_known_q || (qspi_read_addr[DIE_BIT] != cur_die_q);
        end else if (state_d == S_WAIT_DONE) begin
            switch_d = qspi_switch_die;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            status          <= ST_OK;
            qspi_read_flag  <= 1'b0;
            qspi_switch_die <= 1'b0;
            qspi_read_addr  <= '0;
            qspi_mode       <= '0;
            bytes_rcvd      <= '0;
            rem_q           <= '0;
            tmo_q           <= '0;
            abort_pend_q    <= 1'b0;
            cur_die_q       <= 1'b0;
            die_known_q     <= 1'b0;
        end else begin
            req_ready       <= ready_d;
            busy            <= busy_d;
            done            <= done_d;
            status          <= status_d;
            qspi_read_flag  <= flag_d;
            qspi_switch_die <= switch_d;

            // Abort is only meaningful while a request is in progress
            if (state_q == S_IDLE || state_q == S_DONE) begin
                abort_pend_q <= 1'b0;
            end else if (abort) begin
                abort_pend_q <= 1'b1;
            end

            if (accept) begin
                qspi_read_addr <= req_addr;
                rem_q          <= req_len;
                qspi_mode      <= req_mode;
                bytes_rcvd     <= '0;
            end

            if (state_q == S_WAIT_DONE && qspi_write_req && bytes_rcvd != '1) begin
                bytes_rcvd <= bytes_rcvd + LEN_W'(1);
            end

            if (state_q == S_ISSUE) begin
                tmo_q <= TMO_W'(1);
            end else if (state_q == S_WAIT_DONE) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (state_q == S_WAIT_DONE) begin
                if (qspi_read_done) begin
                    cur_die_q      <= qspi_read_addr[DIE_BIT];
                    die_known_q    <= 1'b1;
                    qspi_read_addr <= qspi_read_addr + ADDR_W'(1);
                    rem_q          <= rem_q - LEN_W'(1);
                end else if (tmo_hit) begin
                    die_known_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_read_sequencer.sv
// Directed bench for qspi_read_sequencer with a fixed-latency qspi_controller model.
module tb_qspi_read_sequencer;

    localparam int unsigned LEN_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 4096;

    logic             system_clk = 1'b0;
    logic             system_reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [1:0]       req_mode;
    logic             abort;
    logic             fifo_afull;
    logic             qspi_ready;
    logic             qspi_write_req;
    logic             qspi_read_done;
    logic             qspi_read_flag;
    logic [31:0]      qspi_read_addr;
    logic [1:0]       qspi_mode;
    logic             qspi_switch_die;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [LEN_W-1:0] bytes_rcvd;

    qspi_read_sequencer #(
        .DIE_BIT(25), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .system_clk(system_clk), .system_reset(system_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_mode(req_mode), .abort(abort), .fifo_afull(fifo_afull),
        .qspi_ready(qspi_ready), .qspi_write_req(qspi_write_req),
        .qspi_read_done(qspi_read_done), .qspi_read_flag(qspi_read_flag),
        .qspi_read_addr(qspi_read_addr), .qspi_mode(qspi_mode),
        .qspi_switch_die(qspi_switch_die), .busy(busy), .done(done),
        .status(status), .bytes_rcvd(bytes_rcvd)
    );

    always #5 system_clk = ~system_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Controller model: pushes one byte and completes on the 3rd cycle of read_flag
    logic model_mute = 1'b0;
    int   mdl_cnt    = 0;
    always @(negedge system_clk) begin
        qspi_write_req = 1'b0;
        qspi_read_done = 1'b0;
        if (system_reset) begin
            mdl_cnt = 0;
        end else if (qspi_read_flag && !model_mute) begin
            mdl_cnt++;
            if (mdl_cnt == 3) begin
                qspi_write_req = 1'b1;
                qspi_read_done = 1'b1;
            end
        end else begin
            mdl_cnt = 0;
        end
    end

    // Issue monitor: records address/switch_die at every read_flag rise
    logic [31:0] iss_addr [0:63];
    logic        iss_sw   [0:63];
    int          n_iss    = 0;
    int          flag_hi  = 0;
    int          hold_err = 0;
    logic        flag_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    always @(negedge system_clk) begin
        if (qspi_read_flag && !flag_prev && n_iss < 64) begin
            iss_addr[n_iss] = qspi_read_addr;
            iss_sw[n_iss]   = qspi_switch_die;
            n_iss++;
        end
        if (qspi_read_flag && flag_prev && qspi_read_addr != addr_prev) hold_err++;
        if (qspi_read_flag) flag_hi++;
        flag_prev = qspi_read_flag;
        addr_prev = qspi_read_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] a, input logic [LEN_W-1:0] l, input logic [1:0] m);
        @(negedge system_clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_mode  = m;
        @(negedge system_clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge system_clk);
        end
    endtask

    task automatic wait_flag(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (qspi_read_flag == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge system_clk);
        end
    endtask

    initial begin
        int   base;
        int   fh;
        logic ok;

        system_reset = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_len      = '0;
        req_mode     = '0;
        abort        = 1'b0;
        fifo_afull   = 1'b0;
        qspi_ready   = 1'b1;
        repeat (3) @(negedge system_clk);

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flag", 32'(qspi_read_flag), 32'd0);
        chk("rst_done_status", {29'd0, done, status}, 32'd0);
        system_reset = 1'b0;
        @(negedge system_clk);

        // T1: three bytes from 0xAA, first forces switch_die
        base = n_iss;
        send(32'h0000_00AA, 16'd3, 2'b00);
        wait_done(200, ok);
        chk("t1_done_seen", 32'(ok), 32'd1);
        chk("t1_status", 32'(status), 32'd0);
        chk("t1_bytes", 32'(bytes_rcvd), 32'd3);
        chk("t1_issues", 32'(n_iss - base), 32'd3);
        chk("t1_addr0", iss_addr[base], 32'h0000_00AA);
        chk("t1_addr1", iss_addr[base+1], 32'h0000_00AB);
        chk("t1_addr2", iss_addr[base+2], 32'h0000_00AC);
        chk("t1_sw", {29'd0, iss_sw[base], iss_sw[base+1], iss_sw[base+2]}, 32'b100);
        chk("t1_ready_low_in_done", 32'(req_ready), 32'd0);
        @(negedge system_clk);
        chk("t1_ready_back", 32'(req_ready), 32'd1);

        // T2: die boundary crossing 01FFFFFF -> 02000000
        base = n_iss;
        send(32'h01FF_FFFF, 16'd2, 2'b01);
        wait_done(200, ok);
        chk("t2_done_seen", 32'(ok), 32'd1);
        chk("t2_status", 32'(status), 32'd0);
        chk("t2_addr1", iss_addr[base+1], 32'h0200_0000);
        chk("t2_sw", {30'd0, iss_sw[base], iss_sw[base+1]}, 32'b01);
        @(negedge system_clk);

        // T3: quad mode, 50-cycle FIFO stall after byte 1 (first issue also proves cur_die=1)
        base = n_iss;
        send(32'h0200_0100, 16'd4, 2'b10);
        wait_flag(1'b1, 50, ok);
        wait_flag(1'b0, 50, ok);
        chk("t3_byte1_end", 32'(ok), 32'd1);
        fifo_afull = 1'b1;
        fh = flag_hi;
        repeat (50) @(negedge system_clk);
        chk("t3_stall_no_flag", 32'(flag_hi - fh), 32'd0);
        chk("t3_stall_busy", 32'(busy), 32'd1);
        fifo_afull = 1'b0;
        wait_done(200, ok);
        chk("t3_done_seen", 32'(ok), 32'd1);
        chk("t3_status", 32'(status), 32'd0);
        chk("t3_bytes", 32'(bytes_rcvd), 32'd4);
        chk("t3_issues", 32'(n_iss - base), 32'd4);
        chk("t3_mode", 32'(qspi_mode), 32'd2);
        chk("t3_sw0", 32'(iss_sw[base]), 32'd0);
        @(negedge system_clk);

        // T4: illegal mode completes one cycle after accept, nothing issued
        base = n_iss;
        send(32'h0000_1000, 16'd8, 2'b11);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_status", 32'(status), 32'd1);
        @(negedge system_clk);
        chk("t4_no_issue", 32'(n_iss - base), 32'd0);
        chk("t4_ready", 32'(req_ready), 32'd1);

        // T4b: zero length completes with status ok, nothing issued
        send(32'h0000_2000, 16'd0, 2'b00);
        chk("t4b_done", 32'(done), 32'd1);
        chk("t4b_status", 32'(status), 32'd0);
        @(negedge system_clk);
        chk("t4b_no_issue", 32'(n_iss - base), 32'd0);

        // T5: controller never completes -> timeout after exactly TIMEOUT_CYC flag cycles
        model_mute = 1'b1;
        fh = flag_hi;
        send(32'h0200_0010, 16'd1, 2'b00);
        wait_done(TIMEOUT_CYC + 100, ok);
        chk("t5_done_seen", 32'(ok), 32'd1);
        chk("t5_status", 32'(status), 32'd2);
        chk("t5_flag_cycles", 32'(flag_hi - fh), 32'(TIMEOUT_CYC));
        model_mute = 1'b0;
        @(negedge system_clk);
        // Same die as before the timeout, yet switch_die must be forced
        base = n_iss;
        send(32'h0200_0020, 16'd1, 2'b00);
        wait_done(200, ok);
        chk("t5_next_status", 32'(status), 32'd0);
        chk("t5_next_sw", 32'(iss_sw[base]), 32'd1);
        @(negedge system_clk);

        // T6a: abort during byte 2 lets it finish then stops
        base = n_iss;
        send(32'h0200_0100, 16'd10, 2'b00);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (qspi_read_flag && qspi_read_addr == 32'h0200_0102) begin
                ok = 1'b1;
                break;
            end
            @(negedge system_clk);
        end
        chk("t6_byte2_seen", 32'(ok), 32'd1);
        abort = 1'b1;
        @(negedge system_clk);
        abort = 1'b0;
        wait_done(200, ok);
        chk("t6_done_seen", 32'(ok), 32'd1);
        chk("t6_status", 32'(status), 32'd3);
        chk("t6_bytes", 32'(bytes_rcvd), 32'd3);
        chk("t6_issues", 32'(n_iss - base), 32'd3);
        @(negedge system_clk);

        // T6b: reset in the middle of a transaction
        send(32'h0000_0300, 16'd5, 2'b10);
        wait_flag(1'b1, 50, ok);
        chk("t6r_flag_up", 32'(ok), 32'd1);
        system_reset = 1'b1;
        @(negedge system_clk);
        chk("t6r_flag", 32'(qspi_read_flag), 32'd0);
        chk("t6r_ready_busy", {30'd0, req_ready, busy}, 32'b10);
        chk("t6r_bytes", 32'(bytes_rcvd), 32'd0);
        chk("t6r_addr_mode", qspi_read_addr | 32'(qspi_mode), 32'd0);
        system_reset = 1'b0;
        @(negedge system_clk);
        // cur_die is 0 after reset and this is die 0, so only die_known=0 can force switch_die
        base = n_iss;
        send(32'h0000_0040, 16'd1, 2'b00);
        wait_done(200, ok);
        chk("t6r_next_status", 32'(status), 32'd0);
        chk("t6r_next_sw", 32'(iss_sw[base]), 32'd1);

        chk("addr_hold", 32'(hold_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
